window3x3_gen: RTL and testbench
================================

Name: window3x3_gen

Overview:
- Streaming 3x3 sliding-window generator for the CNN1 convolution path.
- Accepts one signed 16-bit activation per handshake, in raster order: row by row, left to right.
- Emits all nine pixels of every fully-valid 3x3 window in parallel. The pixels are ordered to drive the nine-input tree adder stage, after per-tap weight multiply.
- Holds two line buffers plus a 3x3 register array. No padding is applied: each frame yields (IMG_W-2)*(IMG_H-2) windows.

Parameters:
- DATA_W, 16, pixel width (signed).
- IMG_W, 8, pixels per row; legal range 3..256.
- IMG_H, 8, rows per frame; legal range 3..256.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-low reset (reset while rst==0 at posedge clk).
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  DATA_W  signed pixel.
- out_valid  output  1  win1..win9 hold a valid window.
- out_ready  input  1  downstream accepts the window.
- win1..win9  output  DATA_W each  window, row-major: win1=top-left, win3=top-right, win5=centre, win9=bottom-right (newest pixel).
- out_last  output  1  asserted with the final window of a frame.

Behaviour:
- Pixel accept: in_valid && in_ready at posedge. Window accept: out_valid && out_ready at posedge.
- in_ready = !out_valid || out_ready (combinational). This gives a one-deep output register with full throughput, one pixel per cycle, when out_ready stays high.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1, advancing on each pixel accept.
  - col wraps to 0 and row increments at col==IMG_W-1.
  - At row==IMG_H-1 && col==IMG_W-1 both wrap to 0, and the next pixel starts a new frame.
- Line buffers:
  - LB0 holds row r-1 and LB1 holds row r-2, each IMG_W entries indexed by col.
  - On a pixel accept at col c: LB1[c]<=LB0[c]; LB0[c]<=in_data.
- Window registers:
  - On a pixel accept, each of the three register rows shifts left by one.
  - The new right column is {LB1[c], LB0[c], in_data}, taking values before this cycle's LB update.
- Window emit:
  - A window is emitted when the accepted pixel has row>=2 && col>=2.
  - Next cycle: out_valid=1 and win1..win9 show the updated window.
  - Latency is 1 cycle from the accepting pixel edge.
  - out_last=1 iff the accepting pixel was (IMG_H-1, IMG_W-1).
- Outputs hold stable while out_valid && !out_ready. No pixel is accepted in that state, because in_ready=0.
- out_valid clears on a window accept unless a new window is loaded on the same edge. A simultaneous window accept and pixel accept that produces a window leaves out_valid=1 with the new data.
- Accepting a pixel in rows 0-1 or columns 0-1 updates buffers and registers but emits nothing.
- Row wrap: window registers need no explicit clear. Columns 0-1 of each row refill them before the next emit at col 2.
- Reset (rst==0): col=0, row=0, out_valid=0, out_last=0, win1..win9=0.
  - Line buffer contents are don't-care; they are not read for any emitted window until rewritten.
  - Mid-frame reset discards the partial frame. The next accepted pixel is treated as (0,0).
- Width: pure data movement; no arithmetic on pixels; sign preserved bit-exact.

Test Plan:
- Single 4x4 frame, in_data=r*4+c, out_ready=1, in_valid=1 continuously. Required: exactly 4 windows, each 1 cycle after pixel 10, 11, 14, 15.
  - First window: win1..9 = 0,1,2,4,5,6,8,9,10.
  - Second: 1,2,3,5,6,7,9,10,11.
  - Third: 4,5,6,8,9,10,12,13,14.
  - Fourth: 5,6,7,9,10,11,13,14,15 with out_last=1; out_last=0 on the others.
- Same frame, out_ready held 0 for 5 cycles after the first window. Required: window 0,1,2,... held stable and in_ready=0 throughout; after release, the remaining windows match scenario 1 with no loss or duplication.
- Random in_valid gaps (~40% idle) and random out_ready, on an 8x8 frame (default parameters). Required: 36 windows matching a software reference model; out_last only on the 36th.
- Two back-to-back 5x5 frames, second frame offset by +100. Required: 9 windows per frame; the first window of frame 2 is 100,101,102,105,106,107,110,111,112, with no frame-1 data.
- Negative data: in_data=-1 (0xFFFF) for all pixels of a 3x3 frame. Required: one window, all nine outputs 0xFFFF, out_last=1.
- rst pulsed low after 7 pixels of a 4x4 frame, then a full frame of r*4+c. Required: all outputs 0 during reset; afterwards the window sequence is identical to scenario 1.

Source files
------------

// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_gen
// Purpose  : Streaming 3x3 sliding-window generator (two line buffers + 3x3
//            register array), emitting every fully-valid window in raster order.
// Revision : 1.0 - initial release
// ============================================================================
module window3x3_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic signed [DATA_W-1:0] win9,
  output logic                     out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic signed [DATA_W-1:0] win_q [9];
  logic signed [DATA_W-1:0] win_d [9];
  logic signed [DATA_W-1:0] lb0_q [IMG_W];
  logic signed [DATA_W-1:0] lb1_q [IMG_W];

  logic accept;
  logic emit;
  logic col_last;
  logic row_last;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    win_d       = win_q;
    if (accept) begin
      // Rows shift left; the new right column is {row r-2, row r-1, row r}.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_q[col_q];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_q[col_q];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_data;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = row_last && col_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  // Line buffers are never read for an emitted window before being rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign win1      = win_q[0];
  assign win2      = win_q[1];
  assign win3      = win_q[2];
  assign win4      = win_q[3];
  assign win5      = win_q[4];
  assign win6      = win_q[5];
  assign win7      = win_q[6];
  assign win8      = win_q[7];
  assign win9      = win_q[8];

endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_gen
// Purpose  : Self-checking bench for window3x3_gen at 4x4, 8x8, 5x5 and 3x3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window3x3_gen;

  localparam int NI = 4;
  localparam int WS [NI] = '{4, 8, 5, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        out_last  [NI];
  logic [15:0] in_data   [NI];
  logic [15:0] win       [NI][9];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      window3x3_gen #(.DATA_W(16), .IMG_W(WS[g]), .IMG_H(WS[g])) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
        .out_valid(out_valid[g]), .out_ready(out_ready[g]),
        .win1(win[g][0]), .win2(win[g][1]), .win3(win[g][2]),
        .win4(win[g][3]), .win5(win[g][4]), .win6(win[g][5]),
        .win7(win[g][6]), .win8(win[g][7]), .win9(win[g][8]),
        .out_last(out_last[g])
      );
    end
  endgenerate

  // Reference model: the accepted image plus a linear pixel position.
  logic [15:0]  img   [NI][8][8];
  int           pos   [NI];
  logic         mvalid[NI];
  logic         mlast [NI];
  logic         mzero [NI];
  logic [15:0]  mwin  [NI][9];
  logic [144:0] cap   [NI][64];
  int           ncap  [NI];

  int n_assert = 0;
  int n_fail   = 0;

  int exp4 [4][9] = '{'{0,1,2,4,5,6,8,9,10}, '{1,2,3,5,6,7,9,10,11},
                      '{4,5,6,8,9,10,12,13,14}, '{5,6,7,9,10,11,13,14,15}};
  int exp5_last [9] = '{12,13,14,17,18,19,22,23,24};
  int exp5_f2   [9] = '{100,101,102,105,106,107,110,111,112};
  int expneg    [9] = '{-1,-1,-1,-1,-1,-1,-1,-1,-1};

  function automatic logic [143:0] dut_win(input int k);
    logic [143:0] v;
    for (int i = 0; i < 9; i++) v[(8-i)*16 +: 16] = win[k][i];
    return v;
  endfunction

  function automatic logic [143:0] mdl_win(input int k);
    logic [143:0] v;
    for (int i = 0; i < 9; i++) v[(8-i)*16 +: 16] = mwin[k][i];
    return v;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        pos[k]    <= 0;
        mvalid[k] <= 1'b0;
        mlast[k]  <= 1'b0;
        mzero[k]  <= 1'b1;
        ncap[k]   <= 0;
      end else begin
        if (out_valid[k] && out_ready[k]) begin
          cap[k][ncap[k] % 64] <= {out_last[k], dut_win(k)};
          ncap[k]              <= ncap[k] + 1;
        end
        if (in_valid[k] && (!mvalid[k] || out_ready[k])) begin
          img[k][pos[k] / WS[k]][pos[k] % WS[k]] <= in_data[k];
          pos[k]   <= (pos[k] == WS[k] * WS[k] - 1) ? 0 : pos[k] + 1;
          mzero[k] <= 1'b0;
          if (pos[k] / WS[k] >= 2 && pos[k] % WS[k] >= 2) begin
            mvalid[k] <= 1'b1;
            mlast[k]  <= (pos[k] == WS[k] * WS[k] - 1);
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                mwin[k][i*3+j] <= (i == 2 && j == 2) ? in_data[k]
                                : img[k][pos[k] / WS[k] - 2 + i][pos[k] % WS[k] - 2 + j];
          end else if (out_ready[k]) begin
            mvalid[k] <= 1'b0;
          end
        end else if (out_ready[k]) begin
          mvalid[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #3;
    for (int k = 0; k < NI; k++) begin
      n_assert++;
      if (in_ready[k] !== (!mvalid[k] || out_ready[k])) begin
        n_fail++;
        $display("FAIL in_ready k=%0d t=%0t actual=%b required=%b", k, $time, in_ready[k], !mvalid[k] || out_ready[k]);
      end
      n_assert++;
      if (out_valid[k] !== mvalid[k]) begin
        n_fail++;
        $display("FAIL out_valid k=%0d t=%0t actual=%b required=%b", k, $time, out_valid[k], mvalid[k]);
      end
      if (mvalid[k]) begin
        n_assert++;
        if (dut_win(k) !== mdl_win(k) || out_last[k] !== mlast[k]) begin
          n_fail++;
          $display("FAIL window k=%0d t=%0t actual=%h/%b required=%h/%b", k, $time, dut_win(k), out_last[k], mdl_win(k), mlast[k]);
        end
      end
      if (mzero[k]) begin
        n_assert++;
        if (dut_win(k) !== 144'd0 || out_last[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_zero k=%0d t=%0t actual=%h/%b required=0/0", k, $time, dut_win(k), out_last[k]);
        end
      end
    end
  end

  task automatic run(input int k, input int npix, input int base, input bit allneg,
                     input int idle_pct, input bit rnd_rdy, input int stall_n);
    int n = 0;
    int stall = -1;
    int guard = 0;
    while (n < npix && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (stall_n > 0 && stall < 0 && out_valid[k]) stall = stall_n;
      if (stall > 0) begin
        out_ready[k] = 1'b0;
        stall--;
      end else begin
        out_ready[k] = rnd_rdy ? ($urandom_range(0, 99) < 60) : 1'b1;
      end
      in_valid[k] = ($urandom_range(0, 99) >= idle_pct);
      in_data[k]  = allneg ? 16'hFFFF : 16'(base + n);
      #1;
      if (in_valid[k] && in_ready[k]) n++;
    end
    n_assert++;
    if (n < npix) begin
      n_fail++;
      $display("FAIL pixel_timeout k=%0d actual=%0d required=%0d", k, n, npix);
    end
  endtask

  task automatic idle(input int k, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
  endtask

  task automatic chk_count(input string nm, input int actual, input int req);
    n_assert++;
    if (actual != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, actual, req);
    end
  endtask

  task automatic chk_cap(input string nm, input int k, input int idx, input int e [9], input bit last);
    logic [143:0] v;
    for (int i = 0; i < 9; i++) v[(8-i)*16 +: 16] = 16'(e[i]);
    n_assert++;
    if (cap[k][idx % 64] !== {last, v}) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, cap[k][idx % 64], {last, v});
    end
  endtask

  task automatic chk_frame4(input string nm, input int b);
    chk_count({nm, "_count"}, ncap[0] - b, 4);
    for (int i = 0; i < 4; i++) chk_cap(nm, 0, b + i, exp4[i], i == 3);
  endtask

  initial begin
    int b;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      in_data[k]   = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    b = ncap[0];
    run(0, 16, 0, 1'b0, 0, 1'b0, 0);
    idle(0, 3);
    chk_frame4("s1_4x4", b);

    b = ncap[0];
    run(0, 16, 0, 1'b0, 0, 1'b0, 5);
    idle(0, 3);
    chk_frame4("s2_stall", b);

    b = ncap[1];
    run(1, 64, 0, 1'b0, 40, 1'b1, 0);
    idle(1, 4);
    chk_count("s3_count", ncap[1] - b, 36);
    for (int i = 0; i < 36; i++) begin
      n_assert++;
      if (cap[1][(b + i) % 64][144] !== (i == 35)) begin
        n_fail++;
        $display("FAIL s3_last idx=%0d actual=%b required=%b", i, cap[1][(b + i) % 64][144], i == 35);
      end
    end

    b = ncap[2];
    run(2, 25, 0, 1'b0, 0, 1'b0, 0);
    run(2, 25, 100, 1'b0, 0, 1'b0, 0);
    idle(2, 3);
    chk_count("s4_count", ncap[2] - b, 18);
    chk_cap("s4_f1_last", 2, b + 8, exp5_last, 1'b1);
    chk_cap("s4_f2_first", 2, b + 9, exp5_f2, 1'b0);

    b = ncap[3];
    run(3, 9, 0, 1'b1, 0, 1'b0, 0);
    idle(3, 3);
    chk_count("s5_count", ncap[3] - b, 1);
    chk_cap("s5_neg", 3, b, expneg, 1'b1);

    run(0, 7, 0, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk_count("s6_rst_valid", int'(out_valid[0]), 0);
    rst = 1'b1;
    b = ncap[0];
    run(0, 16, 0, 1'b0, 0, 1'b0, 0);
    idle(0, 3);
    chk_frame4("s6_after_rst", b);

    idle(0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
